// File: rtl/mem_lane_unit.sv
// mem_lane_unit: M-stage load/store lane unit in front of the data-memory port.
// Ports: req_* (request in), m_* (memory port), rsp_* (response out); clk, sync reset.
module mem_lane_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [3:0]          req_op,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                m_req,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W/8-1:0] m_byteen,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic                m_ack,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_data,
   output logic [1:0]          rsp_exc
);
   localparam int OFF_W = $clog2(DATA_W/8);
   localparam int BE_W  = DATA_W/8;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q;
   logic                m_req_q, m_we_q, rsp_valid_q;
   logic [ADDR_W-1:0]   m_addr_q;
   logic [BE_W-1:0]     m_byteen_q;
   logic [DATA_W-1:0]   m_wdata_q, rsp_data_q;
   logic [1:0]          rsp_exc_q;
   logic [3:0]          op_q;
   logic [OFF_W-1:0]    off_q;

   logic                is_b, is_h, is_w, is_d, is_st, legal, misal;
   logic [1:0]          exc_d;
   logic [OFF_W-1:0]    off_d;
   logic [BE_W-1:0]     be_d;
   logic [DATA_W-1:0]   wd_d;
   logic [DATA_W-1:0]   lane, ld_d;

   // request decode: access size, direction and legality
   always_comb begin
      is_b  = 1'b0;
      is_h  = 1'b0;
      is_w  = 1'b0;
      is_d  = 1'b0;
      is_st = 1'b0;
      legal = 1'b1;
      unique case (req_op)
         4'd0:       is_w = 1'b1;
         4'd1, 4'd2: is_b = 1'b1;
         4'd3, 4'd4: is_h = 1'b1;
         4'd5: begin is_w = 1'b1; is_st = 1'b1; end
         4'd6: begin is_b = 1'b1; is_st = 1'b1; end
         4'd7: begin is_h = 1'b1; is_st = 1'b1; end
         4'd8: begin is_w = 1'b1; legal = (DATA_W == 64); end
         4'd9: begin is_d = 1'b1; legal = (DATA_W == 64); end
         4'd10: begin
            is_d  = 1'b1;
            is_st = 1'b1;
            legal = (DATA_W == 64);
         end
         default: legal = 1'b0;
      endcase
      misal = (is_h & req_addr[0]) |
              (is_w & (|req_addr[1:0])) |
              (is_d & (|req_addr[2:0]));
      if (!legal)     exc_d = 2'd3;
      else if (misal) exc_d = is_st ? 2'd2 : 2'd1;
      else            exc_d = 2'd0;
      off_d = req_addr[OFF_W-1:0];
      be_d  = '0;
      wd_d  = '0;
      if (is_st) begin
         if (is_b) begin
            be_d = BE_W'(1) << off_d;
            wd_d = {BE_W{req_wdata[7:0]}};
         end else if (is_h) begin
            be_d = BE_W'(3) << off_d;
            wd_d = {(BE_W/2){req_wdata[15:0]}};
         end else if (is_w) begin
            be_d = BE_W'(15) << off_d;
            wd_d = {(BE_W/4){req_wdata[31:0]}};
         end else begin
            be_d = '1;
            wd_d = req_wdata;
         end
      end
   end

   // load lane select and extension; sized casts of signed
   // values sign-extend, so LW is a pass-through at DATA_W=32
   always_comb begin
      lane = m_rdata >> {off_q, 3'b000};
      unique case (op_q)
         4'd0:    ld_d = DATA_W'($signed(lane[31:0]));
         4'd1:    ld_d = DATA_W'($signed(lane[7:0]));
         4'd2:    ld_d = DATA_W'(lane[7:0]);
         4'd3:    ld_d = DATA_W'($signed(lane[15:0]));
         4'd4:    ld_d = DATA_W'(lane[15:0]);
         4'd8:    ld_d = DATA_W'(lane[31:0]);
         default: ld_d = lane;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         m_req_q     <= 1'b0;
         m_we_q      <= 1'b0;
         m_addr_q    <= '0;
         m_byteen_q  <= '0;
         m_wdata_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_exc_q   <= 2'd0;
         op_q        <= 4'd0;
         off_q       <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  if (exc_d != 2'd0) begin
                     rsp_valid_q <= 1'b1;
                     rsp_exc_q   <= exc_d;
                     rsp_data_q  <= '0;
                     state_q     <= RESP;
                  end else begin
                     m_req_q    <= 1'b1;
                     m_we_q     <= is_st;
                     m_addr_q   <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                     m_byteen_q <= be_d;
                     m_wdata_q  <= wd_d;
                     op_q       <= req_op;
                     off_q      <= off_d;
                     state_q    <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (m_ack) begin
                  m_req_q     <= 1'b0;
                  m_we_q      <= 1'b0;
                  m_byteen_q  <= '0;
                  rsp_valid_q <= 1'b1;
                  rsp_exc_q   <= 2'd0;
                  rsp_data_q  <= m_we_q ? '0 : ld_d;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = (state_q == IDLE);
   assign m_req     = m_req_q;
   assign m_we      = m_we_q;
   assign m_addr    = m_addr_q;
   assign m_byteen  = m_byteen_q;
   assign m_wdata   = m_wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_exc   = rsp_exc_q;
endmodule

// File: doc/mem_lane_unit.md
# mem_lane_unit

Parametrised load/store lane unit between the M-stage datapath and the data-memory port. It accepts one memory request per handshake and drives aligned address, byte enables and lane-replicated store data to memory. It holds the request until memory acknowledges, then returns a sign- or zero-extended load result. Misaligned and illegal accesses are flagged as AdEL/AdES/illegal exceptions without touching memory; the load extension is registered, and the unit supports 32- and 64-bit memory words.

## Interface
- DATA_W, 32: memory word width; legal values 32 or 64.
- ADDR_W, 32: byte address width.
- OFF_W, derived = log2(DATA_W/8): byte-offset bits (2 or 3).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_op  in  4  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 SW, 6 SB, 7 SH, 8 LWU, 9 LD, 10 SD; 11-15 illegal. LWU/LD/SD are legal only when DATA_W=64.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- m_req  out  1  memory access active.
- m_we  out  1  store when high.
- m_addr  out  ADDR_W  req_addr with low OFF_W bits cleared.
- m_byteen  out  DATA_W/8  byte-lane write enables; all zero for loads.
- m_wdata  out  DATA_W  lane-replicated store data.
- m_ack  in  1  memory done; m_rdata valid in the same cycle for loads.
- m_rdata  in  DATA_W  full memory word.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_data  out  DATA_W  extended load data; 0 for stores and exceptions.
- rsp_exc  out  2  0 none, 1 AdEL, 2 AdES, 3 illegal op.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE -> ACCESS on req_valid&&req_ready when the access is legal and aligned. The unit latches op, offset, m_addr, m_we, m_byteen and m_wdata.
- IDLE -> RESP directly on an accepted misaligned or illegal request. No m_req is issued. rsp_exc is set: AdEL for misaligned loads, AdES for misaligned stores, 3 for an illegal op. Illegal takes priority over misalignment.
- Alignment rules: halfword needs addr[0]=0; word needs addr[1:0]=0; doubleword needs addr[2:0]=0. Byte accesses are always aligned.
- ACCESS: m_req is held high with constant outputs until m_ack. On m_ack the unit registers the extended result into rsp_data, sets rsp_exc=0 and goes to RESP.
- RESP: rsp_valid is high. rsp_data and rsp_exc stay stable until rsp_valid&&rsp_ready, then the unit returns to IDLE. A new request cannot be accepted in that same cycle, because req_ready is low outside IDLE.
- Store lanes: SB sets byteen=1<<off and replicates wdata[7:0] across all lanes. SH sets byteen=3<<off and replicates wdata[15:0]. SW sets byteen=0xF<<off and replicates wdata[31:0]. SD sets all ones.
- Load extraction: the lane is selected by the latched offset; b = m_rdata[8*off+:8], h = m_rdata[8*off+:16], w = m_rdata[8*off+:32].
- Load extension: LB and LH sign-extend to DATA_W; LBU, LHU and LWU zero-extend. LW sign-extends when DATA_W=64 and is a pass-through when DATA_W=32. LD is a pass-through.
- m_ack outside ACCESS is ignored.

## Timing
- Reset values: state=IDLE, req_ready=1, m_req=0, m_we=0, m_byteen=0, m_addr=0, m_wdata=0, rsp_valid=0, rsp_data=0, rsp_exc=0.
- Reset mid-operation returns the unit to IDLE next edge and drops m_req. An in-flight memory transaction is abandoned, and a pending response is discarded.
- Accept at edge T: m_req is high from T+1. If m_ack arrives in cycle T+k (k>=1), rsp_valid is high from T+k+1. The minimum accept-to-response latency is 2 cycles.
- Exception path: rsp_valid is high at T+1, and m_req never rises.
- Throughput: one request per 3 cycles at best (IDLE, ACCESS, RESP).
- All outputs are registered except req_ready, which is decoded from state.

## Test plan
- DATA_W=32, LB at addr 0x0000_1003, m_ack on first ACCESS cycle with m_rdata=0x80FF_1234 -> m_addr=0x1000, byteen=0, rsp_data=0xFFFF_FF80, rsp_exc=0, rsp_valid 2 cycles after accept.
- DATA_W=32, SH at addr 0x0000_2002 with wdata=0x0000_BEEF, m_ack after 3 wait cycles -> m_req high for 3 cycles with stable outputs, m_we=1, byteen=0b1100, m_wdata=0xBEEF_BEEF, rsp_data=0.
- DATA_W=32, LW at addr 0x0000_3001 -> no m_req, rsp_valid at T+1 with rsp_exc=1. SH at 0x0000_3001 -> rsp_exc=2. Op 9 (LD) -> rsp_exc=3.
- DATA_W=64, LHU at addr 0x...06 with m_rdata=0xABCD_0000_0000_0000 -> rsp_data=0x0000_0000_0000_ABCD. LW at 0x...04 with m_rdata[63:32]=0x8000_0001 -> rsp_data=0xFFFF_FFFF_8000_0001.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_exc stay constant, req_ready stays 0, and a pending req_valid is not accepted.
- Assert reset during ACCESS (m_ack withheld) -> next cycle m_req=0, state IDLE, req_ready=1, rsp_valid=0. A late m_ack afterwards produces no response.
